// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns pc and ir, runs FETCH -> DECODE -> EXECUTE per instruction.
// Optional single-step HOLD state is enabled with `define FETCH_SEQ_STEP_EN.
module fetch_sequencer #(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  IMEM_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [7:0]          imem_data,
  output logic [7:0]          ir,
  output logic [2:0]          opcode,
  output logic [4:0]          operand,
  output logic                instr_valid,
  input  logic                j,
  input  logic                jc,
  input  logic                neq,
  input  logic                cmp_eq,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                ex_stall,
`ifdef FETCH_SEQ_STEP_EN
  input  logic                step,
`endif
  output logic                exec_commit,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_err,
  output logic [2:0]          dbg_state
);

  // imem handshake: a fetch completes on any rising edge where imem_req and imem_ack are both high;
  // imem_req is held until then, and imem_ack is ignored whenever imem_req is low.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_ERROR   = 3'd3
`ifdef FETCH_SEQ_STEP_EN
    , ST_HOLD  = 3'd4
`endif
  } state_e;

`ifdef FETCH_SEQ_STEP_EN
  localparam state_e ST_IDLE = ST_HOLD;
`else
  localparam state_e ST_IDLE = ST_FETCH;
`endif

  localparam int                CNT_W    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          ir_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                fetch_err_q;

  logic                taken_d;
  logic [PC_WIDTH-1:0] pc_d;
  logic                timeout_d;

  assign taken_d   = j | (jc & (cmp_eq ^ neq));
  assign pc_d      = taken_d ? jump_target : pc_q + PC_WIDTH'(1);
  assign timeout_d = (IMEM_TIMEOUT > 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      cnt_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          // A late ack on the final allowed cycle still wins over the timeout.
          if (imem_ack) begin
            ir_q    <= imem_data;
            cnt_q   <= '0;
            state_q <= ST_DECODE;
          end else if (timeout_d) begin
            fetch_err_q <= 1'b1;
            state_q     <= ST_ERROR;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DECODE: state_q <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (!ex_stall) begin
            pc_q    <= pc_d;
            state_q <= ST_IDLE;
          end
        end
        ST_ERROR: state_q <= ST_ERROR;
`ifdef FETCH_SEQ_STEP_EN
        ST_HOLD: begin
          if (step) state_q <= ST_FETCH;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_DECODE) || (state_q == ST_EXECUTE);
  assign exec_commit = (state_q == ST_EXECUTE) && !ex_stall;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign opcode      = ir_q[7:5];
  assign operand     = ir_q[4:0];
  assign fetch_err   = fetch_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a fetch-address scoreboard plus directed checks of
// branching, stalls, pc wrap, fetch timeout and reset.
module tb_fetch_sequencer;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_ERROR = 3'd3, S_HOLD = 3'd4;
`ifdef FETCH_SEQ_STEP_EN
  localparam logic [2:0] S_RST = S_HOLD;
  localparam logic       REQ_RST = 1'b0;
`else
  localparam logic [2:0] S_RST = S_FETCH;
  localparam logic       REQ_RST = 1'b1;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0] imem_addr, ir, jump_target, pc;
  logic [2:0] opcode, dbg_state;
  logic [4:0] operand;
  logic       imem_req, imem_ack, instr_valid, j, jc, neq, cmp_eq, ex_stall, exec_commit, fetch_err;
  logic [7:0] imem_data;
  logic       step;

  logic [7:0] mem [256];
  logic       ack_en = 1'b0, ack_force = 1'b0;

  assign imem_data = mem[imem_addr];
  assign imem_ack  = ack_force | (ack_en & imem_req);
  // tiny decoder model: 100 = J, 101 = JC, 110 = JC with inverted condition, 111 = J and JC
  assign j   = instr_valid && (opcode == 3'b100 || opcode == 3'b111);
  assign jc  = instr_valid && (opcode == 3'b101 || opcode == 3'b110 || opcode == 3'b111);
  assign neq = instr_valid && (opcode == 3'b110);

  fetch_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .IMEM_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
    .j(j), .jc(jc), .neq(neq), .cmp_eq(cmp_eq), .jump_target(jump_target),
    .ex_stall(ex_stall),
`ifdef FETCH_SEQ_STEP_EN
    .step(step),
`endif
    .exec_commit(exec_commit), .pc(pc), .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  // scoreboard
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_ir = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every completed fetch pops the next expected address; decoded ir is checked against memory
  always @(negedge clock) begin
    if (!reset && imem_req && imem_ack) begin
      if (exp_q.size() == 0) begin
        check("fetch_unexpected", {24'h0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        check("fetch_addr", {24'h0, imem_addr}, {24'h0, exp_q.pop_front()});
        exp_ir = imem_data;
      end
    end
    if (!reset && instr_valid) begin
      check("ir", {24'h0, ir}, {24'h0, exp_ir});
      check("opcode", {29'h0, opcode}, {29'h0, exp_ir[7:5]});
      check("operand", {27'h0, operand}, {27'h0, exp_ir[4:0]});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic en);
    @(negedge clock);
    #1;
    ack_en = 1'b0;
    reset  = 1'b1;
    tick();
    check("q_drained", exp_q.size(), 0);
    check("rst_pc", {24'h0, pc}, 32'h0);
    check("rst_ir", {24'h0, ir}, 32'h0);
    check("rst_err", {31'h0, fetch_err}, 32'h0);
    check("rst_req", {31'h0, imem_req}, {31'h0, REQ_RST});
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_commit", {31'h0, exec_commit}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, {29'h0, S_RST});
    reset = 1'b0;
    if (en) exp_q.push_back(8'h00);
    ack_en = en;
  endtask

  task automatic wait_commit(input int max);
    int n = 0;
    while (exec_commit !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("commit_wait", {31'h0, exec_commit}, 32'h1);
    tick();
  endtask

  task automatic branch_test(input string name, input logic [7:0] instr, input logic cmp,
                             input logic [7:0] tgt, input logic [7:0] exp_pc);
    mem[0] = instr;
    cmp_eq = cmp;
    jump_target = tgt;
    do_reset(1'b1);
    exp_q.push_back(exp_pc);
    wait_commit(10);
    check({name, "_pc"}, {24'h0, pc}, {24'h0, exp_pc});
    check({name, "_addr"}, {24'h0, imem_addr}, {24'h0, exp_pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    cmp_eq = 1'b0;
    jump_target = 8'h00;
    ex_stall = 1'b0;
    step = 1'b1;

`ifdef FETCH_SEQ_STEP_EN
    // single-step: parked in HOLD until step, one instruction, back to HOLD
    step = 1'b0;
    do_reset(1'b1);
    repeat (3) tick();
    check("hold_state", {29'h0, dbg_state}, {29'h0, S_HOLD});
    check("hold_req", {31'h0, imem_req}, 32'h0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_fetch", {29'h0, dbg_state}, {29'h0, S_FETCH});
    wait_commit(10);
    check("step_pc", {24'h0, pc}, 32'h1);
    tick();
    tick();
    check("step_back_hold", {29'h0, dbg_state}, {29'h0, S_HOLD});
`else
    // straight-line code: one commit every third cycle, pc 0..5
    do_reset(1'b1);
    for (int k = 1; k <= 5; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < 15; k++) begin
      check("cadence", {31'h0, exec_commit}, {31'h0, (k % 3 == 2)});
      tick();
    end
    check("seq_pc", {24'h0, pc}, 32'h5);

    // branch resolution
    branch_test("j",        8'h80, 1'b0, 8'h40, 8'h40);
    branch_test("jc_eq",    8'hA0, 1'b1, 8'h10, 8'h10);
    branch_test("jc_ne",    8'hA0, 1'b0, 8'h10, 8'h01);
    branch_test("jcn_eq",   8'hC0, 1'b1, 8'h10, 8'h01);
    branch_test("jcn_ne",   8'hC0, 1'b0, 8'h10, 8'h10);
    branch_test("j_and_jc", 8'hE0, 1'b0, 8'h33, 8'h33);
    branch_test("nobr",     8'h20, 1'b1, 8'h77, 8'h01);

    // execute stall holds pc/ir for four cycles, then a single commit
    mem[0] = 8'h0F;
    do_reset(1'b1);
    exp_q.push_back(8'h01);
    ex_stall = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check("stall_commit", {31'h0, exec_commit}, 32'h0);
      check("stall_pc", {24'h0, pc}, 32'h0);
      check("stall_state", {29'h0, dbg_state}, {29'h0, S_EXEC});
      tick();
    end
    ex_stall = 1'b0;
    #1;
    check("stall_release", {31'h0, exec_commit}, 32'h1);
    tick();
    check("stall_pc_after", {24'h0, pc}, 32'h1);
    check("stall_commit_after", {31'h0, exec_commit}, 32'h0);

    // pc wraps 0xFF -> 0x00
    mem[0] = 8'h80;
    mem[8'hFF] = 8'h00;
    jump_target = 8'hFF;
    do_reset(1'b1);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    wait_commit(10);
    check("wrap_pre", {24'h0, pc}, 32'hFF);
    wait_commit(10);
    check("wrap_post", {24'h0, pc}, 32'h00);

    // fetch timeout: 16 FETCH cycles without ack
    mem[0] = 8'h0F;
    do_reset(1'b0);
    for (int k = 0; k < 15; k++) tick();
    check("to_not_yet", {31'h0, fetch_err}, 32'h0);
    tick();
    check("to_err", {31'h0, fetch_err}, 32'h1);
    check("to_state", {29'h0, dbg_state}, {29'h0, S_ERROR});
    check("to_req", {31'h0, imem_req}, 32'h0);
    check("to_valid", {31'h0, instr_valid}, 32'h0);
    ack_force = 1'b1;
    tick();
    tick();
    ack_force = 1'b0;
    check("to_ack_ignored", {29'h0, dbg_state}, {29'h0, S_ERROR});
    check("to_ir_kept", {24'h0, ir}, 32'h0);

    // ack on the 16th cycle beats the timeout
    do_reset(1'b0);
    for (int k = 0; k < 15; k++) tick();
    exp_q.push_back(8'h00);
    ack_en = 1'b1;
    tick();
    check("late_ack_state", {29'h0, dbg_state}, {29'h0, S_DECODE});
    check("late_ack_err", {31'h0, fetch_err}, 32'h0);
    check("late_ack_ir", {24'h0, ir}, 32'h0F);

    // reset during a stalled EXECUTE at pc 0x40
    mem[0] = 8'h80;
    mem[8'h40] = 8'h0F;
    jump_target = 8'h40;
    do_reset(1'b1);
    exp_q.push_back(8'h40);
    wait_commit(10);
    ex_stall = 1'b1;
    tick();
    tick();
    check("rs_pc", {24'h0, pc}, 32'h40);
    check("rs_state", {29'h0, dbg_state}, {29'h0, S_EXEC});
    do_reset(1'b0);
    ex_stall = 1'b0;
`endif

    check("final_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
